mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter OUTSTANDING, default 4: maximum read transactions in flight at the memory.
REQ-002 Parameter BEATS, default 4: response beats returned per read request, and request beats per write-back.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Client ports ic_ (client 0, I$) and dc_ (client 1, D$), each with the following signals:
- mem_req_valid in 1
- mem_req_ready out 1
- mem_req_addr in 28
- mem_req_rw in 1 (1 = write)
- mem_req_data_valid in 1
- mem_req_data_ready out 1
- mem_req_data_bits in 128
- mem_req_data_mask in 16
- mem_resp_valid out 1
- mem_resp_data out 128
REQ-006 Memory port mem_ uses the same names with directions inverted, and the same widths (28-bit address, 128-bit data, 16-bit mask).

Function
REQ-007 Read request: accepted when mem_req_valid && mem_req_ready with rw=0; it returns BEATS resp beats in order.
REQ-008 Write beat: accepted when mem_req_valid && mem_req_ready && mem_req_data_valid && mem_req_data_ready with rw=1; a write beat produces no response.
REQ-009 Each cycle, at most one client is granted. The granted client's addr, rw, data and mask drive the mem_ port combinationally (zero latency); the other client's mem_req_ready and mem_req_data_ready are 0.
REQ-010 Client eligibility:
- A client is eligible when its mem_req_valid=1.
- A write additionally requires mem_req_data_valid=1.
- A read additionally requires owner-FIFO count < OUTSTANDING.
REQ-011 Arbitration is round-robin. A 1-bit last-grant register updates on each accepted transfer, and the client not last granted wins ties. After reset, dc has priority.
REQ-012 Write lock: accepting a write beat from client X with write-beat counter 0 sets lock owner X. While locked, only X is granted, and only for writes. The lock releases after the BEATS-th beat (counter wraps 3->0).
REQ-013 Owner FIFO: depth OUTSTANDING, 1-bit entries, 2-bit read/write pointers that wrap, count 0..OUTSTANDING. Each accepted read pushes the client id.
REQ-014 Response routing:
- mem_resp_valid is steered to the head entry's client; resp_data fans out to both clients unchanged.
- A 2-bit beat counter increments per resp beat.
- On the BEATS-th beat the counter wraps to 0 and the head pops.
REQ-015 Push and pop in the same cycle leave count unchanged. A push is allowed in the cycle count==OUTSTANDING only if a pop also occurs in that cycle.
REQ-016 mem_resp_valid with an empty FIFO is a protocol error: the response is dropped (no client resp_valid) and a sticky err flag is set, visible to the bench only.
REQ-017 mem_req_valid and mem_req_data_valid are asserted only on behalf of a granted client; mem_req_data_valid=0 for reads.
REQ-018 Granted-client outputs pass through combinationally; ready is never asserted to a client the memory has not made ready.

Reset
REQ-019 Reset asserted asynchronously clears: FIFO pointers/count, beat counter, write-beat counter, lock, err, and last-grant (last-grant=ic, so dc is preferred).
REQ-020 All outputs during reset:
- ic_/dc_ mem_req_ready=0
- ic_/dc_ mem_req_data_ready=0
- ic_/dc_ mem_resp_valid=0
- mem_req_valid=0
- mem_req_data_valid=0
REQ-021 Reset mid-burst abandons in-flight reads; beats arriving after reset deassertion set err (REQ-016).

Structure
REQ-022 const.vh holds MEM_DATA_BITS and MEM_ADDR_BITS (28); the client-id encoding (IC=0, DC=1) is added there.
REQ-023 The owner FIFO is a sub-module, arb_owner_fifo (parameters DEPTH, WIDTH=1), with push, pop, full, empty and head outputs.

Verification
REQ-024 Single ic read at addr 0x0000010, mem ready -> mem sees a read at 0x0000010; 4 resp beats 0xA..0xD reach ic only; dc_mem_resp_valid stays 0.
REQ-025 ic read and dc read both valid in the same cycle after reset -> dc granted first, ic next cycle; beats return to dc first, then ic.
REQ-026 dc write-back of 4 beats with ic read valid throughout -> all 4 dc beats are contiguous on mem; ic is granted only after beat 4.
REQ-027 Issue 5 reads with no responses -> the 5th read is held (ready=0) until the 4th beat of the first read, then accepted in the same cycle as the pop.
REQ-028 Reset pulsed after 2 of 4 beats -> outputs go to 0 immediately; the next 2 beats route to no client and err=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, client-id encoding and request bundle type for the
// two-client memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

    typedef enum logic {
        CLIENT_IC = 1'b0,
        CLIENT_DC = 1'b1
    } client_e;

    typedef struct packed {
        logic                     valid;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic                     rw;
        logic                     data_valid;
        logic [MEM_DATA_BITS-1:0] bits;
        logic [MEM_MASK_BITS-1:0] mask;
    } req_t;

    // A write needs a data beat present; a read needs a free owner slot.
    function automatic logic req_eligible(input req_t r, input logic read_room);
        return r.valid && (r.rw ? r.data_valid : read_room);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory request/response channel; master issues requests, slave serves them.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_req_rw;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
    logic                     mem_resp_valid;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/arb_owner_fifo.sv
// Small circular FIFO recording which client owns each outstanding read.
module arb_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: entry storage is left unreset; pointers and count alone define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = entries[rd_ptr];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I$ and D$, with
// write-burst locking and in-order read response steering.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int BEATS       = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  ic,
    mem_arbiter_if.slave  dc,
    mem_arbiter_if.master mem,
    output logic          err
);
    localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    req_t          ic_req;
    req_t          dc_req;
    req_t          sel;
    client_e       last_grant;
    client_e       lock_owner;
    client_e       grant_id;
    logic          locked;
    logic          grant_valid;
    logic [BW-1:0] wr_beat;
    logic [BW-1:0] resp_beat;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic          resp_live;
    logic          pop;
    logic          room;
    logic          ic_elig;
    logic          dc_elig;
    logic          rd_acc;
    logic          wr_acc;

    assign ic_req = '{valid: ic.mem_req_valid, addr: ic.mem_req_addr, rw: ic.mem_req_rw,
                      data_valid: ic.mem_req_data_valid, bits: ic.mem_req_data_bits,
                      mask: ic.mem_req_data_mask};
    assign dc_req = '{valid: dc.mem_req_valid, addr: dc.mem_req_addr, rw: dc.mem_req_rw,
                      data_valid: dc.mem_req_data_valid, bits: dc.mem_req_data_bits,
                      mask: dc.mem_req_data_mask};

    // A full owner FIFO still accepts a read in the cycle its head retires.
    assign resp_live = reset && mem.mem_resp_valid && !fifo_empty;
    assign pop       = resp_live && (resp_beat == LAST_BEAT);
    assign room      = !fifo_full || pop;

    assign ic_elig = req_eligible(ic_req, room) &&
                     (!locked || (lock_owner == CLIENT_IC && ic_req.rw));
    assign dc_elig = req_eligible(dc_req, room) &&
                     (!locked || (lock_owner == CLIENT_DC && dc_req.rw));

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no
        // latch is inferred.
        grant_valid = 1'b0;
        grant_id    = CLIENT_DC;
        if (reset) begin
            if (ic_elig && dc_elig) begin
                grant_valid = 1'b1;
                grant_id    = (last_grant == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
            end else if (dc_elig) begin
                grant_valid = 1'b1;
                grant_id    = CLIENT_DC;
            end else if (ic_elig) begin
                grant_valid = 1'b1;
                grant_id    = CLIENT_IC;
            end
        end
    end

    assign sel    = (grant_id == CLIENT_IC) ? ic_req : dc_req;
    assign rd_acc = grant_valid && !sel.rw && mem.mem_req_ready;
    assign wr_acc = grant_valid && sel.rw && mem.mem_req_ready && mem.mem_req_data_ready;

    assign mem.mem_req_valid      = grant_valid;
    assign mem.mem_req_addr       = sel.addr;
    assign mem.mem_req_rw         = sel.rw;
    assign mem.mem_req_data_valid = grant_valid && sel.rw;
    assign mem.mem_req_data_bits  = sel.bits;
    assign mem.mem_req_data_mask  = sel.mask;

    assign ic.mem_req_ready      = grant_valid && grant_id == CLIENT_IC && mem.mem_req_ready;
    assign dc.mem_req_ready      = grant_valid && grant_id == CLIENT_DC && mem.mem_req_ready;
    assign ic.mem_req_data_ready = grant_valid && grant_id == CLIENT_IC && sel.rw &&
                                   mem.mem_req_data_ready;
    assign dc.mem_req_data_ready = grant_valid && grant_id == CLIENT_DC && sel.rw &&
                                   mem.mem_req_data_ready;

    assign ic.mem_resp_valid = resp_live && client_e'(fifo_head) == CLIENT_IC;
    assign dc.mem_resp_valid = resp_live && client_e'(fifo_head) == CLIENT_DC;
    assign ic.mem_resp_data  = mem.mem_resp_data;
    assign dc.mem_resp_data  = mem.mem_resp_data;

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_acc),
        .din   (grant_id),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= CLIENT_IC;
            lock_owner <= CLIENT_IC;
            locked     <= 1'b0;
            wr_beat    <= '0;
            resp_beat  <= '0;
            err        <= 1'b0;
        end else begin
            if (rd_acc || wr_acc) last_grant <= grant_id;
            // Every non-final beat keeps the lock on the bursting client.
            if (wr_acc) begin
                if (wr_beat == LAST_BEAT) begin
                    wr_beat <= '0;
                    locked  <= 1'b0;
                end else begin
                    wr_beat    <= wr_beat + BW'(1);
                    locked     <= 1'b1;
                    lock_owner <= grant_id;
                end
            end
            if (resp_live) resp_beat <= (resp_beat == LAST_BEAT) ? '0 : resp_beat + BW'(1);
            if (mem.mem_resp_valid && fifo_empty) err <= 1'b1;
        end
    end

endmodule
